// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared geometry defaults and FSM state encodings for the data cache.
//   DEF_WORD_SIZE  : data/address width (matches the pipeline word size)
//   DEF_NUM_LINES  : number of direct-mapped lines
//   DEF_LINE_WORDS : words per line (memory returns one whole line per fill)
//   cache_state_e  : CACHE_IDLE, CACHE_FILL, CACHE_WRITE, CACHE_WDONE
package data_cache_pkg;
  localparam int DEF_WORD_SIZE  = 16;
  localparam int DEF_NUM_LINES  = 4;
  localparam int DEF_LINE_WORDS = 4;
  typedef enum logic [1:0] {
    CACHE_IDLE,
    CACHE_FILL,
    CACHE_WRITE,
    CACHE_WDONE
  } cache_state_e;
endpackage

// File: rtl/data_cache_array.sv
// data_cache_array: valid/tag/data storage for the direct-mapped cache.
//   Clk, Reset_N     : clock, asynchronous active-low reset (clears valid bits only)
//   index            : line selected for the combinational read port and both write ports
//   valid, tag, line : combinational read of the selected line
//   fill, fill_tag, fill_line : synchronous whole-line write, sets valid
//   word_we, offset, word     : synchronous single-word write into a resident line
module data_cache_array
  import data_cache_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  localparam int OW = $clog2(LINE_WORDS),
  localparam int IW = $clog2(NUM_LINES),
  localparam int TW = WORD_SIZE - IW - OW,
  localparam int LW = WORD_SIZE * LINE_WORDS
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic [IW-1:0]        index,
  output logic                 valid,
  output logic [TW-1:0]        tag,
  output logic [LW-1:0]        line,
  input  logic                 fill,
  input  logic [TW-1:0]        fill_tag,
  input  logic [LW-1:0]        fill_line,
  input  logic                 word_we,
  input  logic [OW-1:0]        offset,
  input  logic [WORD_SIZE-1:0] word
);
  logic [NUM_LINES-1:0] valid_q;
  logic [TW-1:0]        tag_q  [NUM_LINES];
  logic [LW-1:0]        line_q [NUM_LINES];

  always_ff @(posedge Clk or negedge Reset_N)
    if (!Reset_N) valid_q <= '0;
    else if (fill) valid_q[index] <= 1'b1;

  // Tags and data need no reset: nothing reads them while valid is clear.
  always_ff @(posedge Clk)
    if (fill) begin
      tag_q[index]  <= fill_tag;
      line_q[index] <= fill_line;
    end else if (word_we) begin
      line_q[index][offset*WORD_SIZE +: WORD_SIZE] <= word;
    end

  assign valid = valid_q[index];
  assign tag   = tag_q[index];
  assign line  = line_q[index];
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, read-allocate, write-through, no-write-allocate data cache.
//   Clk, Reset_N            : clock, asynchronous active-low reset
//   readM, writeM, address  : CPU request (write wins if both high), held while busy
//   data                    : CPU-driven on writes, cache-driven on read hits, else Z
//   busy                    : stall to the CPU
//   mem_read, mem_write     : line fill / single-word write-through requests
//   mem_address, mem_wdata  : line base or word address, write data (0 when idle)
//   mem_rdata, mem_ack      : filled line (word 0 in [15:0]), one-cycle completion
//   num_hit, num_miss       : read hit/miss counters, present only with CACHE_STATS_EN
module data_cache
  import data_cache_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  localparam int OW = $clog2(LINE_WORDS),
  localparam int IW = $clog2(NUM_LINES),
  localparam int TW = WORD_SIZE - IW - OW,
  localparam int LW = WORD_SIZE * LINE_WORDS
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 busy,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [LW-1:0]        mem_rdata,
  input  logic                 mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]          num_hit,
  output logic [15:0]          num_miss
`endif
);
  cache_state_e state, next;
  logic [OW-1:0] offset;
  logic [IW-1:0] index;
  logic [TW-1:0] tag, line_tag;
  logic [LW-1:0] line;
  logic line_valid, hit, rd_hit;

  assign offset = address[OW-1:0];
  assign index  = address[OW +: IW];
  assign tag    = address[WORD_SIZE-1 -: TW];

  data_cache_array #(
    .WORD_SIZE(WORD_SIZE), .NUM_LINES(NUM_LINES), .LINE_WORDS(LINE_WORDS)
  ) u_array (
    .Clk(Clk), .Reset_N(Reset_N), .index(index),
    .valid(line_valid), .tag(line_tag), .line(line),
    .fill(state == CACHE_FILL && mem_ack), .fill_tag(tag), .fill_line(mem_rdata),
    .word_we(state == CACHE_WRITE && mem_ack && hit), .offset(offset), .word(data)
  );

  assign hit    = line_valid && line_tag == tag;
  assign rd_hit = state == CACHE_IDLE && readM && !writeM && hit;

  always_ff @(posedge Clk or negedge Reset_N)
    if (!Reset_N) state <= CACHE_IDLE;
    else state <= next;

  // A stale mem_ack in IDLE (e.g. from a request abandoned by reset) falls through harmlessly.
  always_comb begin
    next = state == CACHE_IDLE  ? (writeM ? CACHE_WRITE : readM && !hit ? CACHE_FILL : CACHE_IDLE)
         : state == CACHE_FILL  ? (mem_ack ? CACHE_IDLE : CACHE_FILL)
         : state == CACHE_WRITE ? (mem_ack ? CACHE_WDONE : CACHE_WRITE)
         : CACHE_IDLE;
    busy = state == CACHE_IDLE ? writeM || (readM && !hit) : state != CACHE_WDONE;
    mem_read    = state == CACHE_FILL;
    mem_write   = state == CACHE_WRITE;
    mem_address = mem_read ? {address[WORD_SIZE-1:OW], {OW{1'b0}}} : mem_write ? address : '0;
    mem_wdata   = mem_write ? data : '0;
  end

  assign data = rd_hit ? line[offset*WORD_SIZE +: WORD_SIZE] : 'z;

`ifdef CACHE_STATS_EN
  // The held read that hits right after its own fill is the miss completing, not a new hit.
  logic just_filled;
  always_ff @(posedge Clk or negedge Reset_N)
    if (!Reset_N) begin
      just_filled <= 1'b0;
      num_hit     <= '0;
      num_miss    <= '0;
    end else begin
      just_filled <= state == CACHE_FILL && mem_ack;
      if (rd_hit && !just_filled) num_hit <= num_hit + 16'd1;
      if (state == CACHE_IDLE && next == CACHE_FILL) num_miss <= num_miss + 16'd1;
    end
`endif
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed self-checking bench for data_cache (stats checks with CACHE_STATS_EN).
module tb_data_cache;
  logic        Clk = 1'b0;
  logic        Reset_N = 1'b0;
  logic        readM = 1'b0;
  logic        writeM = 1'b0;
  logic [15:0] address = '0;
  wire  [15:0] data;
  logic        busy, mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        tb_drive = 1'b0;
  logic [15:0] tb_wdata = '0;
  int          tests = 0;
  int          fails = 0;
`ifdef CACHE_STATS_EN
  logic [15:0] num_hit, num_miss;
`endif

  assign data = tb_drive ? tb_wdata : 'z;

  data_cache dut (
    .Clk(Clk), .Reset_N(Reset_N), .readM(readM), .writeM(writeM),
    .address(address), .data(data), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .num_hit(num_hit), .num_miss(num_miss)
`endif
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Read miss: memory acks lat cycles after mem_read rises, so busy lasts lat+1 cycles past the request.
  task automatic rd_miss(input logic [15:0] a, input logic [15:0] base, input logic [63:0] ln,
                         input int lat, input int exp_busy, input logic [15:0] exp);
    int busy_n = 0;
    address = a; readM = 1'b1; writeM = 1'b0;
    #1 check("miss_req_busy", busy, 1);
    check("miss_req_no_mem_read", mem_read, 0);
    @(negedge Clk); #1;
    check("fill_mem_read", mem_read, 1);
    check("fill_mem_address", mem_address, base);
    check("fill_no_mem_write", mem_write, 0);
    for (int i = 0; i < lat; i++) begin
      busy_n += int'(busy);
      @(negedge Clk);
    end
    mem_ack = 1'b1; mem_rdata = ln;
    busy_n += int'(busy);
    @(negedge Clk);
    mem_ack = 1'b0;
    #1 check("miss_busy_cycles", busy_n, exp_busy);
    check("miss_done_busy", busy, 0);
    check("miss_done_data", data, exp);
    check("miss_done_mem_read", mem_read, 0);
    @(negedge Clk);
    readM = 1'b0;
  endtask

  task automatic rd_hit(input logic [15:0] a, input logic [15:0] exp);
    address = a; readM = 1'b1; writeM = 1'b0;
    #1 check("hit_busy", busy, 0);
    check("hit_data", data, exp);
    check("hit_no_mem_read", mem_read, 0);
    @(negedge Clk);
    readM = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] w, input int lat);
    address = a; writeM = 1'b1; readM = 1'b0; tb_drive = 1'b1; tb_wdata = w;
    #1 check("wr_req_busy", busy, 1);
    @(negedge Clk); #1;
    check("wr_mem_write", mem_write, 1);
    check("wr_no_mem_read", mem_read, 0);
    check("wr_mem_address", mem_address, a);
    check("wr_mem_wdata", mem_wdata, w);
    check("wr_busy", busy, 1);
    repeat (lat - 1) @(negedge Clk);
    mem_ack = 1'b1;
    @(negedge Clk);
    mem_ack = 1'b0;
    #1 check("wdone_busy", busy, 0);
    check("wdone_mem_write", mem_write, 0);
    check("wdone_mem_wdata", mem_wdata, 0);
    writeM = 1'b0; tb_drive = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    #1 check("rst_busy", busy, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(negedge Clk);
    Reset_N = 1'b1;
    @(negedge Clk);

    rd_miss(16'h0005, 16'h0004, 64'h4444_3333_2222_1111, 3, 4, 16'h2222);
    rd_hit(16'h0006, 16'h3333);

    wr(16'h0005, 16'hBEEF, 2);
    rd_hit(16'h0005, 16'hBEEF);
    rd_hit(16'h0004, 16'h1111);

    wr(16'h0100, 16'h1234, 3);
    rd_miss(16'h0100, 16'h0100, 64'h0000_0000_0000_1234, 1, 2, 16'h1234);

    rd_miss(16'h0045, 16'h0044, 64'h7777_6666_5555_AAAA, 2, 3, 16'h5555);
    rd_miss(16'h0005, 16'h0004, 64'h4444_3333_BEEF_1111, 3, 4, 16'hBEEF);

    address = 16'h0008; readM = 1'b1;
    @(negedge Clk); #1;
    check("pre_rst_fill", mem_read, 1);
    @(negedge Clk);
    Reset_N = 1'b0;
    #1 check("midfill_rst_mem_read", mem_read, 0);
    check("midfill_rst_mem_address", mem_address, 0);
    check("midfill_rst_busy_req", busy, 1);
    readM = 1'b0;
    #1 check("midfill_rst_busy_idle", busy, 0);
    @(negedge Clk);
    Reset_N = 1'b1;
    mem_ack = 1'b1; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    @(negedge Clk);
    mem_ack = 1'b0;
    #1 check("stale_ack_mem_read", mem_read, 0);
    check("stale_ack_busy", busy, 0);
    @(negedge Clk);
    rd_miss(16'h0006, 16'h0004, 64'h4444_3333_BEEF_1111, 2, 3, 16'h3333);

    Reset_N = 1'b0;
    @(negedge Clk);
    Reset_N = 1'b1;
    @(negedge Clk);
    rd_miss(16'h0005, 16'h0004, 64'h4444_3333_BEEF_1111, 1, 2, 16'hBEEF);
    rd_hit(16'h0006, 16'h3333);
    rd_hit(16'h0004, 16'h1111);
    rd_miss(16'h0045, 16'h0044, 64'h7777_6666_5555_AAAA, 1, 2, 16'h5555);
`ifdef CACHE_STATS_EN
    #1 check("stats_num_hit", num_hit, 2);
    check("stats_num_miss", num_miss, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
